// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
// Shared types and constants for the falling-tile spawn sequencer.
//   sched_state_t : scheduler FSM states
//   NUM_SLOTS_DEF : default size of the tile pool
//   LFSR_SEED     : column LFSR seed
//   COL_W         : column index width (4 columns)
//   lfsr_next()   : one step of the 16-bit Fibonacci LFSR (taps 16/14/13/11)
//   pick_col()    : column rule that keeps two consecutive tiles apart
// -----------------------------------------------------------------------------
package piano_pkg;

  localparam int          NUM_SLOTS_DEF = 16;
  localparam int          COL_W         = 2;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PICK,
    S_ISSUE,
    S_STALL
  } sched_state_t;

  // Shift right; feedback from taps 16/14/13/11 enters at the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
  endfunction

  // Bump the candidate by one column when it would repeat the last one.
  function automatic logic [COL_W-1:0] pick_col(input logic [COL_W-1:0] cand,
                                                input logic [COL_W-1:0] prev);
    return (cand == prev) ? cand + COL_W'(1) : cand;
  endfunction

endpackage

// File: rtl/tile_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin finder: returns the first set bit of req, searching
// upward from ptr and wrapping from NUM_SLOTS-1 back to 0.
//   req     : request mask (1 = candidate)
//   ptr     : search start index
//   gnt_idx : index of the first candidate found (0 when none)
//   any     : at least one candidate exists
// -----------------------------------------------------------------------------
module rr_pick
  import piano_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 any
);

  int slot;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise the missing paths infer latches.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    slot    = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot = (int'(ptr) + i) % NUM_SLOTS;
      if (!any && req[slot]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(slot);
      end
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// -----------------------------------------------------------------------------
// tile_scheduler
// Spawn sequencer for the falling-tile pool. Once every SPAWN_GAP frames it
// picks a free slot round-robin, pulses its enable for one cycle and supplies a
// pseudo-random column that never repeats the previous one.
//   Clk, Reset  : system clock, synchronous active-high reset
//   frame_clk   : VGA vertical sync, asynchronous to Clk
//   run         : game active; low returns to IDLE
//   slot_busy   : per-slot "tile on screen" flags
//   spawn_en    : one-hot, one-cycle launch pulse
//   spawn_col   : column of the launch (valid while spawn_en != 0)
//   tile_speed  : pixels per frame for all slots
//   spawn_count : launches since run rose (wraps)
//   stall       : a spawn is due but every slot is occupied
// Build option: define TILE_SPEED_RAMP_EN to raise tile_speed by one every 32
// launches, saturating at MAX_SPEED. Without it tile_speed stays at BASE_SPEED.
// -----------------------------------------------------------------------------
module tile_scheduler
  import piano_pkg::*;
#(
  parameter int         NUM_SLOTS  = NUM_SLOTS_DEF,
  parameter int         SPAWN_GAP  = 30,
  parameter logic [9:0] BASE_SPEED = 10'd2,
  parameter logic [9:0] MAX_SPEED  = 10'd8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 run,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] spawn_en,
  output logic [COL_W-1:0]     spawn_col,
  output logic [9:0]           tile_speed,
  output logic [15:0]          spawn_count,
  output logic                 stall
);

  localparam int          IDX_W    = $clog2(NUM_SLOTS);
  localparam logic [15:0] GAP_LAST = 16'(SPAWN_GAP - 1);

  sched_state_t         state_q, state_d;
  logic                 fs1_q, fs1_d, fs2_q, fs2_d, fs3_q, fs3_d, tick_q, tick_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, sel_idx_q, sel_idx_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [COL_W-1:0]     prev_col_q, prev_col_d;
  logic [NUM_SLOTS-1:0] spawn_en_q, spawn_en_d;
  logic [COL_W-1:0]     spawn_col_q, spawn_col_d;
  logic [9:0]           tile_speed_q, tile_speed_d;
  logic [15:0]          spawn_count_q, spawn_count_d;
  logic                 stall_q, stall_d;

  logic [NUM_SLOTS-1:0] free_mask;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 gap_done;

  // A slot rising busy in the same cycle as the search already counts as busy.
  assign free_mask = ~slot_busy & ~pending_q;
  assign gap_done  = tick_q && (gap_cnt_q == GAP_LAST);

  rr_pick #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) u_rr_pick (
    .req     (free_mask),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_WAIT;
        S_WAIT:  if (gap_done) state_d = S_PICK;
        S_PICK:  state_d = gnt_any ? S_ISSUE : S_STALL;
        S_ISSUE: state_d = S_WAIT;
        S_STALL: if (gnt_any) state_d = S_ISSUE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath logic.
  always_comb begin
    // Two-flop synchronizer followed by a registered rising-edge detector.
    fs1_d  = frame_clk;
    fs2_d  = fs1_q;
    fs3_d  = fs2_q;
    tick_d = fs2_q & ~fs3_q;

    gap_cnt_d     = gap_cnt_q;
    pending_d     = pending_q & ~slot_busy;  // launched slot has shown up busy
    rr_ptr_d      = rr_ptr_q;
    sel_idx_d     = sel_idx_q;
    lfsr_d        = lfsr_q;
    prev_col_d    = prev_col_q;
    spawn_en_d    = '0;
    spawn_col_d   = spawn_col_q;
    spawn_count_d = spawn_count_q;
    stall_d       = (state_d == S_STALL);
`ifdef TILE_SPEED_RAMP_EN
    tile_speed_d  = tile_speed_q;
`else
    tile_speed_d  = (BASE_SPEED > MAX_SPEED) ? MAX_SPEED : BASE_SPEED;
`endif

    unique case (state_q)
      S_IDLE: begin
        gap_cnt_d     = '0;
        pending_d     = '0;
        spawn_count_d = '0;
        tile_speed_d  = BASE_SPEED;
      end
      S_WAIT: begin
        if (tick_q) gap_cnt_d = gap_done ? '0 : gap_cnt_q + 16'd1;
      end
      S_ISSUE: begin
        // Bookkeeping for the pulse on the wire now; runs even if run dropped.
        pending_d[sel_idx_q] = 1'b1;
        rr_ptr_d      = (sel_idx_q == IDX_W'(NUM_SLOTS - 1)) ? '0 : sel_idx_q + IDX_W'(1);
        lfsr_d        = lfsr_next(lfsr_q);
        prev_col_d    = spawn_col_q;
        spawn_count_d = spawn_count_q + 16'd1;
`ifdef TILE_SPEED_RAMP_EN
        if (spawn_count_d[4:0] == 5'd0 && tile_speed_q < MAX_SPEED)
          tile_speed_d = tile_speed_q + 10'd1;
`endif
      end
      default: ;
    endcase

    // The pulse is registered, so it is prepared on the edge entering ISSUE.
    if (state_d == S_ISSUE) begin
      spawn_en_d[gnt_idx] = 1'b1;
      spawn_col_d         = pick_col(lfsr_q[COL_W-1:0], prev_col_q);
      sel_idx_d           = gnt_idx;
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      fs1_q         <= 1'b0;
      fs2_q         <= 1'b0;
      fs3_q         <= 1'b0;
      tick_q        <= 1'b0;
      gap_cnt_q     <= '0;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      sel_idx_q     <= '0;
      lfsr_q        <= LFSR_SEED;
      prev_col_q    <= '0;
      spawn_en_q    <= '0;
      spawn_col_q   <= '0;
      tile_speed_q  <= BASE_SPEED;
      spawn_count_q <= '0;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fs1_q         <= fs1_d;
      fs2_q         <= fs2_d;
      fs3_q         <= fs3_d;
      tick_q        <= tick_d;
      gap_cnt_q     <= gap_cnt_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_idx_q     <= sel_idx_d;
      lfsr_q        <= lfsr_d;
      prev_col_q    <= prev_col_d;
      spawn_en_q    <= spawn_en_d;
      spawn_col_q   <= spawn_col_d;
      tile_speed_q  <= tile_speed_d;
      spawn_count_q <= spawn_count_d;
      stall_q       <= stall_d;
    end
  end

  assign spawn_en    = spawn_en_q;
  assign spawn_col   = spawn_col_q;
  assign tile_speed  = tile_speed_q;
  assign spawn_count = spawn_count_q;
  assign stall       = stall_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tile_scheduler
// Directed bench for tile_scheduler with SPAWN_GAP=3. Expected slots, columns
// and counts are worked out by hand from the LFSR seed and the column rule.
// Define TILE_SPEED_RAMP_EN for both RTL and bench to exercise the speed ramp.
// -----------------------------------------------------------------------------
module tb_tile_scheduler;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        run = 1'b0;
  logic [15:0] slot_busy = '0;
  logic [15:0] spawn_en;
  logic [1:0]  spawn_col;
  logic [9:0]  tile_speed;
  logic [15:0] spawn_count;
  logic        stall;

  bit recycle = 1'b0;  // pulse all slots busy at the end of each frame

  int n_checks = 0;
  int n_fail   = 0;

  int       n_pulses   = 0;
  int       repeat_err = 0;
  int       onehot_err = 0;
  logic [1:0] mon_prev_col = 2'd0;

  tile_scheduler #(
    .NUM_SLOTS  (16),
    .SPAWN_GAP  (3),
    .BASE_SPEED (10'd2),
    .MAX_SPEED  (10'd8)
  ) dut (
    .Clk         (clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .run         (run),
    .slot_busy   (slot_busy),
    .spawn_en    (spawn_en),
    .spawn_col   (spawn_col),
    .tile_speed  (tile_speed),
    .spawn_count (spawn_count),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts launches, checks one-hot and the no-repeat column rule.
  always @(negedge clk) begin
    if (spawn_en !== 16'h0000) begin
      n_pulses++;
      if ($countones(spawn_en) != 1) onehot_err++;
      if (spawn_col == mon_prev_col) repeat_err++;
      mon_prev_col = spawn_col;
    end
    if (Reset) mon_prev_col = 2'd0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain frames of 12 cycles; entered and left at posedge+1.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      repeat (6) @(posedge clk);
      #1 frame_clk = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      if (recycle) slot_busy = 16'hFFFF;
      @(posedge clk);
      #1 slot_busy = 16'h0000 | (recycle ? 16'h0000 : slot_busy);
    end
  endtask

  // Terminal frame: the launch must appear exactly 5 edges after frame_clk rises.
  // action: 0 none, 1 drop run in the ISSUE cycle, 2 assert Reset in that cycle.
  task automatic timed_spawn(input string tag, input logic [15:0] exp_en,
                             input logic [1:0] exp_col, input bit exact, input int action);
    frame_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 check({tag, "_pre"}, spawn_en, 0);
    @(posedge clk);
    #1;
    if (exact) begin
      check({tag, "_en"}, spawn_en, exp_en);
      check({tag, "_col"}, spawn_col, exp_col);
    end else begin
      check({tag, "_onehot"}, $countones(spawn_en), 1);
    end
    if (action == 1) run = 1'b0;
    else if (action == 2) Reset = 1'b1;
    @(posedge clk);
    #1 check({tag, "_end"}, spawn_en, 0);
    Reset     = 1'b0;
    frame_clk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
`ifdef TILE_SPEED_RAMP_EN
    logic [9:0] exp_speed_64 = 10'd4;
    logic [9:0] exp_speed_230 = 10'd8;
`else
    logic [9:0] exp_speed_64 = 10'd2;
    logic [9:0] exp_speed_230 = 10'd2;
`endif

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", spawn_en, 0);
    check("rst_col", spawn_col, 0);
    check("rst_stall", stall, 0);
    check("rst_count", spawn_count, 0);
    check("rst_speed", tile_speed, 2);
    Reset = 1'b0;
    frames(5);
    check("idle_pulses", n_pulses, 0);
    check("idle_count", spawn_count, 0);
    check("idle_speed", tile_speed, 2);

    // Basic spawn: slot 0 column 1, then slot 1 column 0 three frames later.
    run = 1'b1;
    @(posedge clk);
    #1;
    frames(2);
    timed_spawn("basic0", 16'h0001, 2'd1, 1'b1, 0);
    check("basic0_count", spawn_count, 1);
    frames(2);
    timed_spawn("basic1", 16'h0002, 2'd0, 1'b1, 0);
    check("basic1_count", spawn_count, 2);

    // Pending and round-robin from a fresh reset.
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    slot_busy = 16'h0003;
    @(posedge clk);
    #1;
    frames(2);
    timed_spawn("rr_slot2", 16'h0004, 2'd1, 1'b1, 0);
    slot_busy = 16'h0000;
    frames(2);
    timed_spawn("rr_slot3", 16'h0008, 2'd0, 1'b1, 0);

    // Full pool: stall until slot 5 frees.
    slot_busy = 16'hFFFF;
    frames(3);
    check("full_stall", stall, 1);
    check("full_no_en", spawn_en, 0);
    slot_busy = 16'hFFDF;
    @(posedge clk);
    #1;
    check("full_slot5_en", spawn_en, 16'h0020);
    check("full_slot5_col", spawn_col, 1);
    check("full_stall_clr", stall, 0);
    @(posedge clk);
    #1 check("full_slot5_end", spawn_en, 0);
    slot_busy = 16'h0000;

    // Run drop clears the count; then a long run for the column rule and ramp.
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("drop_count", spawn_count, 0);
    run = 1'b1;
    recycle = 1'b1;
    @(posedge clk);
    #1 base = n_pulses;
    frames(192);
    check("ramp64_count", spawn_count, 64);
    check("ramp64_speed", tile_speed, exp_speed_64);
    frames(498);
    check("long_pulses", n_pulses - base, 230);
    check("long_count", spawn_count, 230);
    check("long_speed", tile_speed, exp_speed_230);
    check("col_no_repeat", repeat_err, 0);
    check("onehot", onehot_err, 0);

    // Abort: run falls during ISSUE; the pulse still completes.
    frames(2);
    base = n_pulses;
    timed_spawn("abort", 16'h0000, 2'd0, 1'b0, 1);
    check("abort_pulses", n_pulses - base, 1);
    check("abort_count", spawn_count, 0);
    check("abort_speed", tile_speed, 2);
    check("abort_stall", stall, 0);
    frames(3);
    check("abort_idle_pulses", n_pulses - base, 1);

    // Reset during ISSUE; afterwards the sequence restarts from the seed.
    run = 1'b1;
    @(posedge clk);
    #1;
    frames(2);
    timed_spawn("rst_issue", 16'h0000, 2'd0, 1'b0, 2);
    check("rst_issue_count", spawn_count, 0);
    check("rst_issue_col", spawn_col, 0);
    check("rst_issue_speed", tile_speed, 2);
    frames(2);
    timed_spawn("post_rst", 16'h0001, 2'd1, 1'b1, 0);
    check("post_rst_count", spawn_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Spawn sequencer for the falling-tile pool. It owns the enables of the 16 `tile_maker` slots and decides, once per spawn interval of video frames, which free slot launches the next tile and in which of the 4 columns. It sits between the VGA vertical-sync frame clock and the tile pool, and also drives the shared tile speed.

## Interface
Parameters:
- `NUM_SLOTS`, default 16: number of tile slots (one `spawn_en` bit each).
- `SPAWN_GAP`, default 30: frames between spawns, minimum 1.
- `BASE_SPEED`, default 10'd2: tile speed after reset or when idle.
- `MAX_SPEED`, default 10'd8: ceiling for the speed ramp.

Ports:
- `Clk`, input, 1: system clock (50 MHz).
- `Reset`, input, 1: synchronous, active-high.
- `frame_clk`, input, 1: `VGA_VS`, asynchronous to `Clk`.
- `run`, input, 1: game active; low forces idle.
- `slot_busy`, input, NUM_SLOTS: the `intile` flags from the tile slots; 1 = tile on screen.
- `spawn_en`, output, NUM_SLOTS: one-hot, one-cycle launch pulse.
- `spawn_col`, output, 2: column for the launch; valid only while `spawn_en` ≠ 0.
- `tile_speed`, output, 10: pixels per frame, fed to all slots.
- `spawn_count`, output, 16: tiles launched since `run` rose; wraps.
- `stall`, output, 1: a spawn is due but no slot is free.

## Operation
- **Frame tick.** `frame_clk` passes through a 2-flop synchronizer, then a rising-edge detector. The result is a 1-cycle `tick`.
- **States.** IDLE, WAIT, PICK, ISSUE, STALL.
- **IDLE.**
  - `gap_cnt`=0, `pending`=0, `spawn_count`=0, `tile_speed`=BASE_SPEED.
  - Goes to WAIT when `run`=1.
- **WAIT.**
  - On `tick`: if `gap_cnt`==SPAWN_GAP-1, clear it and go to PICK; otherwise increment it.
  - No change between ticks.
- **PICK.**
  - Free mask = `~slot_busy & ~pending`.
  - Round-robin search starts at `rr_ptr` and wraps at NUM_SLOTS-1 back to 0.
  - If any slot is free, latch its index and go to ISSUE; otherwise go to STALL.
- **ISSUE.** In this single cycle:
  - `spawn_en`[idx]=1 and `spawn_col` is driven.
  - `pending`[idx] is set and `rr_ptr`=idx+1 (mod NUM_SLOTS).
  - The LFSR steps once and `spawn_count` increments.
  - Next state is WAIT.
- **STALL.**
  - `stall`=1.
  - Re-evaluates the free mask every cycle and goes to ISSUE on the first free slot.
  - Ticks arriving during STALL are not counted; the gap restarts after the issue.
- **Pending mask.** `pending`[i] clears in the cycle `slot_busy`[i] is seen high. This covers the lag between launch and the slot's `intile` going high.
- **Column.**
  - 16-bit Fibonacci LFSR, taps 16/14/13/11, seed 16'hACE1.
  - Candidate = `lfsr`[1:0]. If the candidate equals the previous column, use candidate+1 mod 4, so two consecutive tiles never share a column.
  - The previous column resets to 2'b00.
- **run drop.** `run`=0 in any state moves to IDLE on the next edge; a pulse being issued in that same cycle still completes. The LFSR is not reseeded on `run` and keeps its state.
- **Simultaneous events.** `slot_busy`[i] rising in the same cycle as PICK: the slot counts as busy.

## Timing
- `tick` is 3 `Clk` cycles after `frame_clk` rises (2 synchronizer cycles plus the edge register).
- The terminal `tick` enters PICK on the next edge; `spawn_en` is high on the cycle after that, i.e. 2 cycles after the terminal tick.
- All outputs are registered.
- Reset values:
  - state=IDLE, `spawn_en`=0, `spawn_col`=0, `stall`=0, `spawn_count`=0.
  - `tile_speed`=BASE_SPEED, `rr_ptr`=0, `pending`=0, `lfsr`=16'hACE1.
- Reset mid-ISSUE suppresses the pulse; `spawn_en` is 0 on the following cycle.

## Configuration
- `TILE_SPEED_RAMP_EN` defined: each time `spawn_count`[4:0] wraps to 0 (every 32 launches), `tile_speed` increments by 1, saturating at MAX_SPEED. It returns to BASE_SPEED in IDLE.
- Not defined: `tile_speed` is held at BASE_SPEED, and the ramp logic is absent.

## Structure
- Package `piano_pkg` holds:
  - the state enum `sched_state_t`;
  - `NUM_SLOTS_DEF`;
  - `LFSR_SEED` = 16'hACE1;
  - `COL_W` = 2.
- One sub-module, `rr_pick`: combinational round-robin finder. Inputs are `req`[NUM_SLOTS] and `ptr`; outputs are `gnt_idx` and `any`.

## Test plan
- **Reset and idle:** Reset high 2 cycles, `run`=0, 5 frames → `spawn_en`=0, `tile_speed`=2, `spawn_count`=0 throughout.
- **Basic spawn:** `run`=1, all slots free, SPAWN_GAP=3 → first pulse on `spawn_en`[0] 2 cycles after the 3rd tick; the next pulse hits slot 1, 3 frames later.
- **Pending and round-robin:** `slot_busy`=16'h0003, pending cleared, `rr_ptr`=0 → grant to slot 2; `rr_ptr` becomes 3.
- **Full pool:** `slot_busy`=16'hFFFF at the due spawn → `stall`=1. Drop `slot_busy`[5] → `spawn_en`[5] next cycle and `stall`=0.
- **Column rule:** run 200 spawns → `spawn_col` never repeats back-to-back; the first column is `lfsr` 16'hACE1[1:0]=1, adjusted per the rule.
- **Ramp and abort:** with `TILE_SPEED_RAMP_EN`, 64 spawns → `tile_speed`=4. Deassert `run` during ISSUE → the pulse completes, then IDLE and `tile_speed`=2.
